// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave port among NUM_REQ requesters and
// completes each transfer on pready, slave error, or a wait-state timeout.
//
// state  | meaning
// IDLE   | bus idle; grants the next requester unless a completion pulse is out
// SETUP  | psel high, penable low, address/control presented
// ACCESS | psel and penable high, waiting for pready or timeout
module apb_rr_master #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk_i,
  input  logic                      presetn_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_done_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q;
  logic [GW-1:0]       last_grant_q;
  logic [CW-1:0]       wait_cnt_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [NUM_REQ-1:0]  rsp_done_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [GW-1:0]       grant_d;
  logic                grant_vld_d;
  int                  cand;

  // First pending requester strictly after last_grant_q, wrapping.
  always_comb begin
    grant_d     = last_grant_q;
    grant_vld_d = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld_d && req_valid_i[GW'(cand)]) begin
        grant_vld_d = 1'b1;
        grant_d     = GW'(cand);
      end
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_REQ;
      wait_cnt_q   <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_done_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_done_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // The completion cycle never grants, so the finishing requester can drop req_valid.
          if (grant_vld_d && (rsp_done_q == '0)) begin
            last_grant_q <= grant_d;
            pwrite_q     <= req_write_i[grant_d];
            paddr_q      <= req_addr_i[grant_d*ADDR_W +: ADDR_W];
            pwdata_q     <= req_wdata_i[grant_d*DATA_W +: DATA_W];
            psel_q       <= 1'b1;
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            psel_q                   <= 1'b0;
            penable_q                <= 1'b0;
            rsp_done_q[last_grant_q] <= 1'b1;
            rsp_err_q                <= pslverr_i;
            rsp_rdata_q              <= pwrite_q ? '0 : prdata_i;
            state_q                  <= IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            psel_q                   <= 1'b0;
            penable_q                <= 1'b0;
            rsp_done_q[last_grant_q] <= 1'b1;
            rsp_err_q                <= 1'b1;
            state_q                  <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_done_o  = rsp_done_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed and randomized requests against a small
// memory slave, checked against a transaction-level round-robin/memory model.
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            pclk    = 1'b0;
  logic            presetn = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata, prdata;
  logic            pready, pslverr;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk_i(pclk), .presetn_i(presetn),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_done_o(rsp_done), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 pclk = ~pclk;

  function automatic logic [31:0] init_pat(input logic [7:0] a);
    return {8'hA5, a, ~a, a};
  endfunction

  // Slave: memory with programmable wait states, error and stuck-not-ready.
  logic [DW-1:0] mem [0:255];
  bit            mem_init_done;
  int            acc_cnt;
  int            slv_waits;
  bit            slv_stuck, slv_err;

  assign pready  = psel && penable && !slv_stuck && (acc_cnt >= slv_waits);
  assign pslverr = slv_err && pready;
  assign prdata  = mem[paddr];

  always @(posedge pclk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_pat(8'(a));
      mem_init_done <= 1'b1;
    end else if (psel && penable && pready && pwrite && !pslverr) begin
      mem[paddr] <= pwdata;
    end
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  // Reference model state
  int            total = 0;
  int            bad   = 0;
  int            last_g;
  logic [31:0]   exp_mem [0:255];
  bit            m_wr   [N];
  logic [7:0]    m_addr [N];
  logic [31:0]   m_data [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i, input bit w, input logic [7:0] a, input logic [31:0] d);
    m_wr[i]   = w;
    m_addr[i] = a;
    m_data[i] = d;
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_valid[i]           = 1'b1;
  endtask

  function automatic int next_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_g + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One arbitration round, started in a cycle where the DUT samples req_valid at the next edge.
  task automatic round(input int waits, input bit stuck, input bit serr,
                       input bit drop_mid, input bit rereq, input int add_idx);
    int          g, n, exp_n;
    bit          e_wr, e_err;
    logic [7:0]  e_a;
    logic [31:0] e_d, e_rd;
    logic [N-1:0] e_done;
    g = next_grant(req_valid);
    if (g < 0) g = 0;
    slv_waits = waits;
    slv_stuck = stuck;
    slv_err   = serr;
    e_wr = m_wr[g];
    e_a  = m_addr[g];
    e_d  = m_data[g];
    exp_n = stuck ? TO + 2 : 3 + waits;
    if (stuck) begin
      e_err = 1'b1;
      e_rd  = 32'h0;
    end else begin
      e_err = serr;
      e_rd  = e_wr ? 32'h0 : exp_mem[e_a];
      if (e_wr && !serr) exp_mem[e_a] = e_d;
    end
    e_done    = '0;
    e_done[g] = 1'b1;
    last_g    = g;
    n = 0;
    while (n < exp_n + 4) begin
      @(posedge pclk); #1;
      n++;
      if (|rsp_done) break;
      if (n == 1) begin
        chk("setup_sel", 64'({psel, penable}), 64'(2'b10));
        chk("setup_paddr", 64'(paddr), 64'(e_a));
        chk("setup_ctl", 64'({pwrite, pwdata}), 64'({e_wr, e_d}));
        if (drop_mid) begin
          req_valid[g]          = 1'b0;
          req_write[g]          = ~e_wr;
          req_addr[g*AW +: AW]  = ~e_a;
          req_wdata[g*DW +: DW] = ~e_d;
        end
        if (add_idx >= 0)
          drive_req(add_idx, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
      end else begin
        chk("access_sel", 64'({psel, penable}), 64'(2'b11));
        chk("access_paddr", 64'(paddr), 64'(e_a));
        chk("access_ctl", 64'({pwrite, pwdata}), 64'({e_wr, e_d}));
      end
    end
    chk("latency", 64'(n), 64'(exp_n));
    chk("done_grant", 64'(rsp_done), 64'(e_done));
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    chk("done_bus_idle", 64'({psel, penable}), 64'(2'b00));
    if (!rereq) req_valid[g] = 1'b0;
    slv_stuck = 1'b0;
    slv_err   = 1'b0;
    @(posedge pclk); #1;
    chk("done_one_cycle", 64'(rsp_done), 64'(0));
  endtask

  initial begin
    int c;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    slv_waits = 0;
    slv_stuck = 1'b0;
    slv_err   = 1'b0;
    last_g    = N - 1;
    for (int a = 0; a < 256; a++) exp_mem[a] = init_pat(8'(a));
    for (int i = 0; i < N; i++) begin
      m_wr[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end

    // Reset values
    #12;
    chk("rst_sel", 64'({psel, penable, pwrite}), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_done", 64'(rsp_done), 64'(0));
    chk("rst_rsp", 64'({rsp_err, rsp_rdata}), 64'(0));
    @(posedge pclk); #1;
    presetn = 1'b1;

    // No requests: stays idle
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk("idle_psel", 64'({psel, rsp_done}), 64'(0));
    end

    // Write then read back, zero wait states
    drive_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    round(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    drive_req(0, 1'b0, 8'h10, 32'h0);
    round(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Wait states
    drive_req(0, 1'b0, 8'h10, 32'h0);
    round(5, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Slave error on write, then read-back, then a request dropped during SETUP
    drive_req(1, 1'b1, 8'h20, 32'h12345678);
    round(1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    drive_req(1, 1'b0, 8'h20, 32'h0);
    round(0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("no_repeat_done", 64'(rsp_done), 64'(0));
    end

    // Timeout
    drive_req(2, 1'b0, 8'h05, 32'h0);
    round(0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Reset in the middle of ACCESS
    drive_req(0, 1'b1, 8'h30, 32'hCAFE0001);
    slv_stuck = 1'b1;
    c = 0;
    while (!penable && c < 10) begin
      @(posedge pclk); #1;
      c++;
    end
    chk("t1_in_access", 64'({psel, penable}), 64'(2'b11));
    #2;
    presetn = 1'b0;
    #1;
    chk("t1_rst_sel", 64'({psel, penable}), 64'(0));
    chk("t1_rst_done", 64'(rsp_done), 64'(0));
    chk("t1_rst_paddr", 64'({pwrite, paddr, pwdata}), 64'(0));
    last_g    = N - 1;
    req_valid = '0;
    slv_stuck = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Fairness: 0,1,2,3,0,1 then with only 1 and 2 pending 2,1,2
    for (int i = 0; i < N; i++)
      drive_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    round(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    round(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    round(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    round(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    round(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    round(0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    round(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    round(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    round(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Randomized traffic
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && ($urandom_range(0, 1) == 1))
          drive_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
      if (req_valid == '0)
        drive_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 15)), $urandom);
      round(int'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
